// File: rtl/signal_pkg.sv
// signal_pkg: phase encoding and phase-counter width shared by the signal controller
package signal_pkg;
    typedef enum logic [1:0] {PH_ALLRED = 2'd0, PH_GREEN = 2'd1, PH_YELLOW = 2'd2} phase_t;
    function automatic int cnt_width(input int g, input int y, input int a);
        int m;
        m = (g > y) ? g : y;
        m = (m > a) ? m : a;
        return (m > 1) ? $clog2(m) : 1;
    endfunction
endpackage

// File: rtl/rr_next_dir.sv
// rr_next_dir: first set req bit searching cyclically from cur+1 (cur last); ports req, cur -> nxt, defaults to cur+1
module rr_next_dir #(
    parameter int NUM_DIR = 4
) (
    input  logic [NUM_DIR-1:0]         req,
    input  logic [$clog2(NUM_DIR)-1:0] cur,
    output logic [$clog2(NUM_DIR)-1:0] nxt
);
    localparam int W = $clog2(NUM_DIR);
    logic [W-1:0] idx;
    always_comb begin
        nxt = W'((int'(cur) + 1) % NUM_DIR);
        idx = '0;
        for (int k = NUM_DIR; k >= 1; k--) begin
            idx = W'((int'(cur) + k) % NUM_DIR);
            nxt = req[idx] ? idx : nxt;
        end
    end
endmodule

// File: rtl/multiway_signal_ctrl.sv
// multiway_signal_ctrl: ALLRED->GREEN->YELLOW signal sequencer; ports clk, reset, en, req -> red/yellow/green lamps, active_dir, phase
module multiway_signal_ctrl
    import signal_pkg::*;
#(
    parameter int NUM_DIR       = 4,
    parameter int GREEN_CYC     = 50,
    parameter int YELLOW_CYC    = 10,
    parameter int ALLRED_CYC    = 2,
    parameter int REST_ON_GREEN = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic [NUM_DIR-1:0]         req,
    output logic [NUM_DIR-1:0]         red,
    output logic [NUM_DIR-1:0]         yellow,
    output logic [NUM_DIR-1:0]         green,
    output logic [$clog2(NUM_DIR)-1:0] active_dir,
    output logic [1:0]                 phase
);
    localparam int DW = $clog2(NUM_DIR);
    localparam int CW = cnt_width(GREEN_CYC, YELLOW_CYC, ALLRED_CYC);
    phase_t ph;
    logic [CW-1:0] cnt;
    logic [DW-1:0] nxt;
    logic [NUM_DIR-1:0] own, nxt_oh;
    logic hold;
    assign own    = NUM_DIR'(1) << active_dir;
    assign nxt_oh = NUM_DIR'(1) << nxt;
    assign phase  = ph;
    // green rests only when no other approach is waiting
    assign hold   = (REST_ON_GREEN != 0) && ((req & ~own) == '0);
    rr_next_dir #(.NUM_DIR(NUM_DIR)) u_rr (.req(req), .cur(active_dir), .nxt(nxt));
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ph         <= PH_ALLRED;
            cnt        <= CW'(ALLRED_CYC - 1);
            active_dir <= DW'(NUM_DIR - 1);
            red        <= '1;
            yellow     <= '0;
            green      <= '0;
        end else if (en) begin
            if (cnt != '0) cnt <= cnt - CW'(1);
            else if (ph == PH_ALLRED) begin
                ph         <= PH_GREEN;
                cnt        <= CW'(GREEN_CYC - 1);
                active_dir <= nxt;
                red        <= ~nxt_oh;
                green      <= nxt_oh;
            end else if (ph == PH_GREEN && hold) cnt <= CW'(GREEN_CYC - 1);
            else if (ph == PH_GREEN) begin
                ph     <= PH_YELLOW;
                cnt    <= CW'(YELLOW_CYC - 1);
                green  <= '0;
                yellow <= own;
            end else begin
                ph     <= PH_ALLRED;
                cnt    <= CW'(ALLRED_CYC - 1);
                yellow <= '0;
                red    <= '1;
            end
        end
    end
endmodule

// File: doc/multiway_signal_ctrl.md
MULTIWAY_SIGNAL_CTRL -- requirements
Module: multiway_signal_ctrl

Interface
REQ-001 SHALL have parameter NUM_DIR, default 4, number of approaches (legal 2..8).
REQ-002 SHALL have parameter GREEN_CYC, default 50, green phase length in clk cycles (legal >=1).
REQ-003 SHALL have parameter YELLOW_CYC, default 10, yellow phase length in clk cycles (legal >=1).
REQ-004 SHALL have parameter ALLRED_CYC, default 2, all-red clearance length in clk cycles (legal >=1).
REQ-005 SHALL have parameter REST_ON_GREEN, default 0; when set to 1, green is held while no other approach requests.
REQ-006 SHALL have port clk, input, 1, clock; all state changes on its rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port en, input, 1, run enable; 0 freezes the phase timer and state.
REQ-009 SHALL have port req, input, NUM_DIR, per-approach demand (bit i = approach i).
REQ-010 SHALL have ports red, yellow and green, each output, NUM_DIR wide, registered lamp drives.
REQ-011 SHALL have port active_dir, output, $clog2(NUM_DIR), the approach that owns or last owned green.
REQ-012 SHALL have port phase, output, 2, current state: 0 ALLRED, 1 GREEN, 2 YELLOW.

Function
REQ-013 SHALL implement states ALLRED -> GREEN -> YELLOW -> ALLRED, with no other transitions except reset.
REQ-014 SHALL hold each state for exactly its *_CYC cycles using a down-counter loaded with CYC-1 on entry; the transition occurs on the edge where the count is 0 and en=1.
REQ-015 SHALL, on the final ALLRED cycle, select the next approach as the first set req bit searching cyclically from active_dir+1 (the current approach is searched last); if req is all zero, it SHALL select (active_dir+1) mod NUM_DIR.
REQ-016 SHALL sample req only on the ALLRED decision edge (REQ-015) and, if REST_ON_GREEN=1, on the green-expiry edge.
REQ-017 SHALL, with REST_ON_GREEN=1 at green expiry, reload the green timer instead of going to YELLOW when req, excluding bit active_dir, is zero.
REQ-018 SHALL drive in GREEN: green[active_dir]=1, red[active_dir]=0, and all other approaches red only.
REQ-019 SHALL drive in YELLOW: yellow[active_dir]=1 and all other approaches red only.
REQ-020 SHALL drive in ALLRED: every approach red only.
REQ-021 SHALL keep, for every approach at every cycle, exactly one of red/yellow/green asserted.
REQ-022 SHALL update lamp outputs on the same edge as the state change (registered, 0-cycle lag relative to phase).
REQ-023 SHALL, with en=0, hold state, counter and lamps unchanged; resuming continues the remaining count.
REQ-024 SHALL wrap active_dir from NUM_DIR-1 to 0.

Reset
REQ-025 SHALL, on reset assertion, immediately (asynchronously) force: phase=ALLRED, all red=1, all yellow=0, all green=0, active_dir=NUM_DIR-1, counter=ALLRED_CYC-1.
REQ-026 SHALL, on reset mid-GREEN or mid-YELLOW, drop to all-red without passing through yellow.
REQ-027 SHALL give approach 0 the first green after reset release when req=0.

Structure
REQ-028 SHALL place the phase encoding constants and the counter-width calculation in shared package signal_pkg.
REQ-029 SHALL implement the cyclic first-set search as sub-module rr_next_dir (combinational, parameterised by NUM_DIR).

Verification (NUM_DIR=4, GREEN_CYC=5, YELLOW_CYC=2, ALLRED_CYC=1 unless stated)
REQ-030 SHALL verify: reset released with req=0, en=1 -> 1 cycle ALLRED, dir0 green 5 cycles, yellow 2, ALLRED 1, then dir1 green; dir3 is followed by dir0.
REQ-031 SHALL verify: req=4'b1000 held while dir0 is green -> the next green is dir3 (dir1 and dir2 skipped).
REQ-032 SHALL verify: req=4'b0101 while dir0 is green -> the next green is dir2, then dir0, alternating.
REQ-033 SHALL verify: en=0 for 3 cycles mid-green -> green lasts 8 cycles of wall time in total, and lamps stay constant while en=0.
REQ-034 SHALL verify: reset pulse in the 3rd green cycle -> all red within the same cycle, no yellow, and dir0 green after ALLRED.
REQ-035 SHALL verify: REST_ON_GREEN=1, NUM_DIR=2, req=2'b01 -> dir0 stays green indefinitely; raising req[1] -> yellow at the next expiry, then dir1 green.
